// File: rtl/bullet_pool.sv
// Pool of NUM multi-lane bullets: periodic spawn into the lowest free slot, per-frame upward motion,
// per-lane collision clear; pixel query answers 2 cycles after request; no backpressure, a shot into a full pool is dropped and flagged.
module bullet_pool #(
    parameter int NUM          = 8,
    parameter int LANES        = 3,
    parameter int XW           = 10,
    parameter int YW           = 10,
    parameter int COLOR_W      = 12,
    parameter int SPEED        = 4,
    parameter int SHOOT_PERIOD = 8,
    parameter int LANE_PITCH   = 16,
    parameter int WIDTH        = 4,
    parameter int HEIGHT       = 12,
    parameter logic [COLOR_W-1:0] CENTER_COLOR = 12'hFF0,
    parameter logic [COLOR_W-1:0] SIDE_COLOR   = 12'h0FF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick_i,
    input  logic                       fire_en_i,
    input  logic [LANES-1:0]           lane_mask_i,
    input  logic [XW-1:0]              origin_x_i,
    input  logic [YW-1:0]              origin_y_i,
    input  logic [XW-1:0]              req_x_addr_i,
    input  logic [YW-1:0]              req_y_addr_i,
    input  logic                       hit_i,
    output logic [COLOR_W-1:0]         vga_rgb_o,
    output logic                       vga_alpha_o,
    output logic [$clog2(NUM+1)-1:0]   active_cnt_o,
    output logic                       shot_drop_o
);
    localparam int AW     = $clog2(NUM+1);
    localparam int CNT_W  = (SHOOT_PERIOD > 1) ? $clog2(SHOOT_PERIOD) : 1;
    localparam int XE     = XW + 4;
    localparam int YE     = YW + 4;
    localparam int CENTER = LANES / 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SHOOT_PERIOD - 1);

    logic [LANES-1:0] r_live [NUM];
    logic [XW-1:0]    r_x    [NUM];
    logic [YW-1:0]    r_y    [NUM];
    logic [CNT_W-1:0] r_cnt;
    logic [XW-1:0]    r_qx1, r_qx2;
    logic [YW-1:0]    r_qy1, r_qy2;
    logic [AW-1:0]    r_active;
    logic             r_drop;

    logic [LANES-1:0] w_cover [NUM];
    logic [NUM-1:0]   w_free;
    logic [NUM-1:0]   w_sel;
    logic [LANES-1:0] w_spawn_live;
    logic             w_found;
    logic             w_alpha;
    logic             w_center;
    logic             w_spawn_req;
    logic             w_spawn_go;
    logic             w_drop;
    logic [AW-1:0]    w_busy;

    // Sums are widened by 4 bits so lanes near the screen edge never wrap.
    function automatic logic lane_covers(input logic [XW-1:0] bx, input logic [YW-1:0] by,
                                         input int k, input logic [XW-1:0] px,
                                         input logic [YW-1:0] py);
        logic [XE-1:0] lo;
        logic [YE-1:0] top;
        lo  = XE'(bx) + XE'(k * LANE_PITCH);
        top = YE'(by);
        return (XE'(px) >= lo) && (XE'(px) < lo + XE'(WIDTH)) &&
               (YE'(py) >= top) && (YE'(py) < top + YE'(HEIGHT));
    endfunction

    always_comb begin
        w_alpha  = 1'b0;
        w_center = 1'b0;
        w_busy   = '0;
        for (int s = 0; s < NUM; s++) begin
            w_free[s] = ~|r_live[s];
            w_busy    = w_busy + AW'(~w_free[s]);
            for (int k = 0; k < LANES; k++) begin
                w_cover[s][k] = r_live[s][k] & lane_covers(r_x[s], r_y[s], k, r_qx2, r_qy2);
            end
            w_alpha  = w_alpha | (|w_cover[s]);
            w_center = w_center | w_cover[s][CENTER];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int s = 0; s < NUM; s++) begin
            w_sel[s] = w_free[s] & ~w_found;
            w_found  = w_found | w_free[s];
        end
        for (int k = 0; k < LANES; k++) begin
            w_spawn_live[k] = lane_mask_i[k] &&
                (XE'(origin_x_i) + XE'(k * LANE_PITCH) + XE'(WIDTH) <= XE'(2 ** XW));
        end
        w_spawn_req = fire_en_i & frame_tick_i & (r_cnt == LAST);
        w_spawn_go  = w_spawn_req & (|w_spawn_live) & w_found;
        w_drop      = w_spawn_req & (|w_spawn_live) & ~w_found;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM; s++) begin
                r_live[s] <= '0;
                r_x[s]    <= '0;
                r_y[s]    <= '0;
            end
            r_cnt    <= '0;
            r_qx1    <= '0;
            r_qx2    <= '0;
            r_qy1    <= '0;
            r_qy2    <= '0;
            r_active <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_qx1    <= req_x_addr_i;
            r_qy1    <= req_y_addr_i;
            r_qx2    <= r_qx1;
            r_qy2    <= r_qy1;
            r_active <= w_busy;
            r_drop   <= w_drop;
            if (!fire_en_i) begin
                r_cnt <= '0;
            end else if (frame_tick_i) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
            end
            for (int s = 0; s < NUM; s++) begin
                if (w_spawn_go && w_sel[s]) begin
                    r_live[s] <= w_spawn_live;
                    r_x[s]    <= origin_x_i;
                    r_y[s]    <= origin_y_i;
                end else if (frame_tick_i && !w_free[s] && (YE'(r_y[s]) < YE'(SPEED))) begin
                    r_live[s] <= '0;
                end else begin
                    // Collision clear and movement apply together.
                    r_live[s] <= r_live[s] & ~(hit_i ? w_cover[s] : '0);
                    if (frame_tick_i && !w_free[s]) begin
                        r_y[s] <= r_y[s] - YW'(SPEED);
                    end
                end
            end
        end
    end

    assign vga_alpha_o  = w_alpha;
    assign vga_rgb_o    = w_alpha ? (w_center ? CENTER_COLOR : SIDE_COLOR) : '0;
    assign active_cnt_o = r_active;
    assign shot_drop_o  = r_drop;
endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: a slot-level model predicts every cycle's outputs.
module tb_bullet_pool;
    localparam int NUM = 8, LANES = 3, CENTER = 1, PER = 2;
    localparam int SPEED = 4, PITCH = 16, W = 4, H = 12;

    logic        clk, rst, frame_tick, fire_en, hit;
    logic [2:0]  lane_mask;
    logic [9:0]  origin_x, origin_y, req_x, req_y;
    logic [11:0] vga_rgb;
    logic        vga_alpha;
    logic [3:0]  active_cnt;
    logic        shot_drop;

    bullet_pool #(.SHOOT_PERIOD(PER)) dut (
        .clk(clk), .rst(rst), .frame_tick_i(frame_tick), .fire_en_i(fire_en),
        .lane_mask_i(lane_mask), .origin_x_i(origin_x), .origin_y_i(origin_y),
        .req_x_addr_i(req_x), .req_y_addr_i(req_y), .hit_i(hit),
        .vga_rgb_o(vga_rgb), .vga_alpha_o(vga_alpha),
        .active_cnt_o(active_cnt), .shot_drop_o(shot_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: whole bullets as plain integers.
    int m_live [NUM][LANES];
    int m_x [NUM];
    int m_y [NUM];
    int m_cnt, m_active, m_drop;
    int q1x, q1y, q2x, q2y;

    typedef struct { int alpha; int rgb; int active; int drop; } exp_t;
    exp_t sb[$];

    function automatic int slot_busy(int s);
        for (int k = 0; k < LANES; k++) if (m_live[s][k] != 0) return 1;
        return 0;
    endfunction

    function automatic int m_cover(int s, int k, int px, int py);
        int lo;
        lo = m_x[s] + k * PITCH;
        return (m_live[s][k] != 0 && px >= lo && px < lo + W && py >= m_y[s] && py < m_y[s] + H) ? 1 : 0;
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        int cen;
        e.alpha = 0; cen = 0;
        for (int s = 0; s < NUM; s++)
            for (int k = 0; k < LANES; k++)
                if (m_cover(s, k, q2x, q2y) != 0) begin
                    e.alpha = 1;
                    if (k == CENTER) cen = 1;
                end
        e.rgb    = (e.alpha == 0) ? 0 : (cen != 0 ? 'hFF0 : 'h0FF);
        e.active = m_active;
        e.drop   = m_drop;
        return e;
    endfunction

    task automatic model_edge();
        int cov [NUM][LANES];
        int wb [NUM];
        int nl [LANES];
        int busy, tgt, go, sreq;
        if (rst) begin
            for (int s = 0; s < NUM; s++) begin
                for (int k = 0; k < LANES; k++) m_live[s][k] = 0;
                m_x[s] = 0; m_y[s] = 0;
            end
            m_cnt = 0; m_active = 0; m_drop = 0;
            q1x = 0; q1y = 0; q2x = 0; q2y = 0;
            return;
        end
        busy = 0;
        for (int s = 0; s < NUM; s++) begin
            wb[s] = slot_busy(s);
            busy += wb[s];
            for (int k = 0; k < LANES; k++) cov[s][k] = m_cover(s, k, q2x, q2y);
        end
        sreq = (fire_en && frame_tick && m_cnt == PER - 1) ? 1 : 0;
        if (!fire_en) m_cnt = 0;
        else if (frame_tick) m_cnt = (m_cnt == PER - 1) ? 0 : m_cnt + 1;
        go = 0;
        for (int k = 0; k < LANES; k++) begin
            nl[k] = (((lane_mask >> k) & 1) == 1 && int'(origin_x) + k * PITCH + W <= 1024) ? 1 : 0;
            if (nl[k] != 0) go = 1;
        end
        tgt = -1;
        if (sreq != 0 && go != 0)
            for (int s = 0; s < NUM; s++) if (tgt < 0 && wb[s] == 0) tgt = s;
        m_drop = (sreq != 0 && go != 0 && tgt < 0) ? 1 : 0;
        for (int s = 0; s < NUM; s++) begin
            if (s == tgt) begin
                for (int k = 0; k < LANES; k++) m_live[s][k] = nl[k];
                m_x[s] = int'(origin_x); m_y[s] = int'(origin_y);
            end else begin
                if (hit) for (int k = 0; k < LANES; k++) if (cov[s][k] != 0) m_live[s][k] = 0;
                if (frame_tick && wb[s] != 0) begin
                    if (m_y[s] >= SPEED) m_y[s] -= SPEED;
                    else for (int k = 0; k < LANES; k++) m_live[s][k] = 0;
                end
            end
        end
        m_active = busy;
        q2x = q1x; q2y = q1y;
        q1x = int'(req_x); q1y = int'(req_y);
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
        model_edge();
        sb.push_back(m_expect());
    endtask

    task automatic tick_step();
        frame_tick = 1'b1;
        clk_step();
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic query(input int x, input int y);
        req_x = 10'(x); req_y = 10'(y);
        clk_step();
        clk_step();
    endtask

    task automatic query_hit(input int x, input int y);
        query(x, y);
        hit = 1'b1;
        clk_step();
        hit = 1'b0;
    endtask

    task automatic shot();
        tick_step();
        clk_step();
        tick_step();
    endtask

    // Monitor: every cycle the DUT presents a pixel, occupancy and drop flag.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (int'(vga_alpha) != e.alpha || int'(vga_rgb) != e.rgb ||
                    int'(active_cnt) != e.active || int'(shot_drop) != e.drop) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t alpha %0d/%0d rgb %h/%h active %0d/%0d drop %0d/%0d (got/exp)",
                             $time, vga_alpha, e.alpha, vga_rgb, e.rgb, active_cnt, e.active, shot_drop, e.drop);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s, k;
        rst = 1'b1; frame_tick = 1'b0; fire_en = 1'b0; hit = 1'b0;
        lane_mask = 3'b000; origin_x = '0; origin_y = '0; req_x = '0; req_y = '0;
        clk_step();
        rst = 1'b0;
        chk("reset_alpha", int'(vga_alpha), 0);
        chk("reset_active", int'(active_cnt), 0);
        chk("reset_drop", int'(shot_drop), 0);

        // Basic spawn and coverage
        fire_en = 1'b1; lane_mask = 3'b111; origin_x = 10'd100; origin_y = 10'd400;
        shot();
        fire_en = 1'b0;
        query(117, 405);
        chk("center_alpha", int'(vga_alpha), 1);
        chk("center_rgb", int'(vga_rgb), 'hFF0);
        query(104, 405);
        chk("right_edge_excl", int'(vga_alpha), 0);
        query(101, 405);
        chk("side_rgb", int'(vga_rgb), 'h0FF);

        // Movement and expiry
        tick_step();
        query(100, 396); chk("move396_in", int'(vga_alpha), 1);
        query(100, 395); chk("move396_out", int'(vga_alpha), 0);
        tick_step();
        query(100, 392); chk("move392_in", int'(vga_alpha), 1);
        fire_en = 1'b1; origin_x = 10'd300; origin_y = 10'd3;
        shot();
        fire_en = 1'b0;
        clk_step();
        chk("two_active", int'(active_cnt), 2);
        tick_step();
        chk("expiry_lag", int'(active_cnt), 2);
        clk_step();
        chk("expiry_drop", int'(active_cnt), 1);

        // Pool exhaustion
        origin_y = 10'd1000;
        fire_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            origin_x = 10'(200 + i * 60);
            shot();
            if (i == 7) chk("drop_pulse", int'(shot_drop), 1);
            clk_step();
            if (i == 7) chk("drop_one_cycle", int'(shot_drop), 0);
        end
        fire_en = 1'b0;
        chk("pool_full", int'(active_cnt), 8);
        for (int j = 0; j < LANES; j++) query_hit(m_x[3] + j * PITCH, m_y[3]);
        clk_step(); clk_step();
        chk("slot3_cleared", int'(active_cnt), 7);
        fire_en = 1'b1; origin_x = 10'd900;
        shot();
        fire_en = 1'b0;
        clk_step(); clk_step();
        chk("refill_active", int'(active_cnt), 8);
        query(901, m_y[3] + 2);
        chk("refill_slot3", int'(vga_alpha), 1);

        // Lane-selective hit on the center lane
        query_hit(917, m_y[3] + 2);
        query(917, m_y[3] + 2); chk("center_cleared", int'(vga_alpha), 0);
        query(901, m_y[3] + 2); chk("lane0_alive", int'(vga_alpha), 1);
        chk("lane0_rgb", int'(vga_rgb), 'h0FF);
        query(933, m_y[3] + 2); chk("lane2_alive", int'(vga_alpha), 1);

        // Reset mid-flight coincident with a frame tick
        rst = 1'b1; frame_tick = 1'b1;
        clk_step();
        rst = 1'b0; frame_tick = 1'b0;
        chk("midreset_alpha", int'(vga_alpha), 0);
        chk("midreset_active", int'(active_cnt), 0);
        chk("midreset_drop", int'(shot_drop), 0);
        fire_en = 1'b1; origin_x = 10'd1000; origin_y = 10'd500; lane_mask = 3'b111;
        tick_step(); clk_step(); clk_step();
        chk("no_early_shot", int'(active_cnt), 0);
        tick_step();
        fire_en = 1'b0;
        clk_step(); clk_step();
        chk("first_shot", int'(active_cnt), 1);

        // Lane overflow at the right screen edge
        query(1017, 505); chk("ovf_lane1_alpha", int'(vga_alpha), 1);
        chk("ovf_lane1_rgb", int'(vga_rgb), 'hFF0);
        query(1003, 505); chk("ovf_lane0_rgb", int'(vga_rgb), 'h0FF);
        lane_mask = 3'b100; fire_en = 1'b1;
        shot();
        chk("ovf_no_drop", int'(shot_drop), 0);
        fire_en = 1'b0;
        clk_step(); clk_step();
        chk("ovf_no_spawn", int'(active_cnt), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 599) == 0);
            frame_tick = ($urandom_range(0, 5) == 0);
            fire_en    = ($urandom_range(0, 7) != 0);
            hit        = ($urandom_range(0, 2) == 0);
            lane_mask  = 3'($urandom);
            origin_x   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(960, 1023)) : 10'($urandom);
            origin_y   = 10'($urandom_range(100, 1023));
            if ($urandom_range(0, 9) < 7) begin
                s = $urandom_range(0, NUM - 1);
                k = $urandom_range(0, LANES - 1);
                req_x = 10'(m_x[s] + k * PITCH + $urandom_range(0, 7) - 2);
                req_y = 10'(m_y[s] + $urandom_range(0, 15) - 2);
            end else begin
                req_x = 10'($urandom);
                req_y = 10'($urandom);
            end
            clk_step();
        end
        rst = 1'b0; hit = 1'b0; frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
